// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   function automatic int piso_cnt_w(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: load/ready handshake in, one bit per clock out.
// state | meaning
// IDLE  | no frame in flight; ready high, serial outputs quiet
// SHIFT | emitting a frame; counter holds bits remaining after the current one
module piso_tx
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic             ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             done
);

   localparam int CW = piso_cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   piso_state_e      state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic last_bit;
   logic head_bit;
   logic accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs come only from registered state, never from load/din.
   assign last_bit   = (state_q == SHIFT) && (cnt_q == '0);
   assign head_bit   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
   assign ready      = (state_q == IDLE) || last_bit;
   assign sout_valid = (state_q == SHIFT);
   assign sout       = (state_q == SHIFT) ? head_bit : 1'b0;
   assign done       = last_bit;
   assign accept     = load && ready;

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      cnt_d   = cnt_q;
      if (accept) begin
         state_d = SHIFT;
         shreg_d = din;
         cnt_d   = CNT_LAST;
      end else if (state_q == SHIFT) begin
         shreg_d = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0} : {1'b0, shreg_q[WIDTH-1:1]};
         if (last_bit) begin
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances driven in lockstep.
module tb_piso_tx;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         load;
   logic [W-1:0] din;
   logic         ready_m, sout_m, valid_m, done_m;
   logic         ready_l, sout_l, valid_l, done_l;

   int total;
   int bad;

   // Reference: bits remaining in the frame (0 = idle) and the captured word.
   int           rem_m, rem_l;
   logic [W-1:0] word_m, word_l;

   typedef struct {
      logic         ld;
      logic [W-1:0] d;
      logic [3:0]   exp_m;
      logic [3:0]   exp_l;
   } vec_t;

   vec_t vecs[24];

   piso_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .rst(rst), .load(load), .din(din),
      .ready(ready_m), .sout(sout_m), .sout_valid(valid_m), .done(done_m)
   );

   piso_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .rst(rst), .load(load), .din(din),
      .ready(ready_l), .sout(sout_l), .sout_valid(valid_l), .done(done_l)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] model_out(input int rem, input logic [W-1:0] word, input bit msb);
      int   k;
      logic b;
      if (rem == 0) return 4'b1000;
      k = W - rem;
      b = msb ? word[W-1-k] : word[k];
      return {rem == 1, b, 1'b1, rem == 1};
   endfunction

   task automatic model_edge(input logic ld, input logic [W-1:0] d);
      if (ld && rem_m <= 1) begin
         word_m = d; rem_m = W;
      end else if (rem_m > 0) rem_m--;
      if (ld && rem_l <= 1) begin
         word_l = d; rem_l = W;
      end else if (rem_l > 0) rem_l--;
   endtask

   task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: {ready,sout,valid,done} got=%b expected=%b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_model(input string name);
      chk({name, "/msb"}, {ready_m, sout_m, valid_m, done_m}, model_out(rem_m, word_m, 1'b1));
      chk({name, "/lsb"}, {ready_l, sout_l, valid_l, done_l}, model_out(rem_l, word_l, 1'b0));
   endtask

   task automatic tick(input logic ld, input logic [W-1:0] d);
      load = ld;
      din  = d;
      @(posedge clk);
      model_edge(ld, d);
      #1;
   endtask

   task automatic set_vec(input int i, input logic ld, input logic [W-1:0] d,
                          input logic [3:0] em, input logic [3:0] el);
      vecs[i].ld = ld; vecs[i].d = d; vecs[i].exp_m = em; vecs[i].exp_l = el;
   endtask

   initial begin
      logic [3:0] exp_stream;
      total = 0; bad = 0;
      rem_m = 0; rem_l = 0; word_m = '0; word_l = '0;
      rst = 1'b1; load = 1'b0; din = '0;

      // {ready,sout,valid,done} expected in the cycle after each edge
      set_vec( 0, 1, 4'b1001, 4'b0110, 4'b0110);
      set_vec( 1, 0, 4'b0000, 4'b0010, 4'b0010);
      set_vec( 2, 0, 4'b0000, 4'b0010, 4'b0010);
      set_vec( 3, 0, 4'b0000, 4'b1111, 4'b1111);
      set_vec( 4, 0, 4'b0000, 4'b1000, 4'b1000);
      set_vec( 5, 1, 4'b1010, 4'b0110, 4'b0010);
      set_vec( 6, 1, 4'b1010, 4'b0010, 4'b0110);
      set_vec( 7, 1, 4'b1010, 4'b0110, 4'b0010);
      set_vec( 8, 1, 4'b1010, 4'b1011, 4'b1111);
      set_vec( 9, 1, 4'b0110, 4'b0010, 4'b0010);
      set_vec(10, 0, 4'b0110, 4'b0110, 4'b0110);
      set_vec(11, 0, 4'b0110, 4'b0110, 4'b0110);
      set_vec(12, 0, 4'b0110, 4'b1011, 4'b1011);
      set_vec(13, 0, 4'b0000, 4'b1000, 4'b1000);
      set_vec(14, 1, 4'b1101, 4'b0110, 4'b0110);
      set_vec(15, 0, 4'b0000, 4'b0110, 4'b0010);
      set_vec(16, 0, 4'b0000, 4'b0010, 4'b0110);
      set_vec(17, 0, 4'b0000, 4'b1111, 4'b1111);
      set_vec(18, 0, 4'b0000, 4'b1000, 4'b1000);
      set_vec(19, 1, 4'b1001, 4'b0110, 4'b0110);
      set_vec(20, 0, 4'b1001, 4'b0010, 4'b0010);
      set_vec(21, 1, 4'b1111, 4'b0010, 4'b0010);
      set_vec(22, 0, 4'b1111, 4'b1111, 4'b1111);
      set_vec(23, 0, 4'b0000, 4'b1000, 4'b1000);

      // Reset held for two cycles, then idle with load low
      repeat (2) @(posedge clk);
      #1;
      chk("in_reset/msb", {ready_m, sout_m, valid_m, done_m}, 4'b1000);
      chk("in_reset/lsb", {ready_l, sout_l, valid_l, done_l}, 4'b1000);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 4'b1111);
         chk("idle/msb", {ready_m, sout_m, valid_m, done_m}, 4'b1000);
         chk("idle/lsb", {ready_l, sout_l, valid_l, done_l}, 4'b1000);
      end

      for (int i = 0; i < 24; i++) begin
         tick(vecs[i].ld, vecs[i].d);
         chk($sformatf("vec%0d/msb", i), {ready_m, sout_m, valid_m, done_m}, vecs[i].exp_m);
         chk($sformatf("vec%0d/lsb", i), {ready_l, sout_l, valid_l, done_l}, vecs[i].exp_l);
         chk_model($sformatf("vec%0d_model", i));
      end

      // Async reset in the middle of bit 2, checked before the next edge
      tick(1'b1, 4'b1011);
      tick(1'b0, 4'b0000);
      chk("pre_rst/msb", {ready_m, sout_m, valid_m, done_m}, 4'b0010);
      #2 rst = 1'b1;
      #1;
      chk("async_rst/msb", {ready_m, sout_m, valid_m, done_m}, 4'b1000);
      chk("async_rst/lsb", {ready_l, sout_l, valid_l, done_l}, 4'b1000);
      rem_m = 0; rem_l = 0;
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("post_rst/msb", {ready_m, sout_m, valid_m, done_m}, 4'b1000);
      exp_stream = 4'b0101;
      tick(1'b1, 4'b0101);
      for (int k = 0; k < W; k++) begin
         chk($sformatf("after_rst_bit%0d", k), {1'b0, sout_m, valid_m, 1'b0},
             {1'b0, exp_stream[W-1-k], 1'b1, 1'b0});
         chk_model($sformatf("after_rst_bit%0d_model", k));
         tick(1'b0, 4'b0000);
      end
      chk_model("after_rst_idle");

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         tick(($urandom_range(0, 3) != 0), W'($urandom));
         chk_model("random");
      end
      tick(1'b0, 4'b0000);
      repeat (W) tick(1'b0, 4'b0000);
      chk_model("drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
